obstacle_drawer: RTL and testbench



---
 rtl/obstacle_pkg.sv | 28 ++
 rtl/rect_scanner.sv | 40 ++++
 rtl/obstacle_drawer.sv | 155 +++++++++++++++
 tb/tb_obstacle_drawer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obstacle_pkg : screen geometry, colours and FSM encoding (rev 1.0)       |
// +--------------------------------------------------------------------------+
package obstacle_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BG    = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;

  // Signed width for the obstacle left edge; spans -OBS_W..SCREEN_W+OBS_W.
  localparam int POS_W = 9;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ERASE = 3'd1;
  localparam state_t S_MOVE  = 3'd2;
  localparam state_t S_DRAW  = 3'd3;
  localparam state_t S_FIN   = 3'd4;

  function automatic logic [6:0] clamp_row(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rect_scanner : column-major col/row counter with last flag (rev 1.0)     |
// +--------------------------------------------------------------------------+
module rect_scanner #(
  parameter int COLS  = 8,
  parameter int ROWS  = 120,
  parameter int COL_W = 3,
  parameter int ROW_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (row == ROW_LAST) begin
        row <= '0;
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/obstacle_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obstacle_drawer : erase/move/redraw pixel writer for the scrolling       |
// | obstacle. Optional OBSTACLE_PASSED_EN adds the passed score pulse.       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module obstacle_drawer #(
  parameter int         SCREEN_W   = obstacle_pkg::SCREEN_W,
  parameter int         SCREEN_H   = obstacle_pkg::SCREEN_H,
  parameter int         OBS_W      = 8,
  parameter int         GAP_H      = 30,
  parameter int         STEP       = 1,
  parameter logic [2:0] OBS_COLOUR = obstacle_pkg::COL_GREEN,
`ifdef OBSTACLE_PASSED_EN
  parameter int         BIRD_X     = 20,
`endif
  parameter logic [2:0] BG_COLOUR  = obstacle_pkg::COL_BG
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] gap_y,
  output logic [7:0] x_coord,
  output logic [6:0] y_coord,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
`ifdef OBSTACLE_PASSED_EN
  output logic       passed,
`endif
  output logic [8:0] obs_x
);

  import obstacle_pkg::*;

  localparam int COL_W = (OBS_W > 1) ? $clog2(OBS_W) : 1;

  localparam logic signed [POS_W-1:0] POS_RESET = POS_W'(SCREEN_W);
  localparam logic signed [POS_W-1:0] POS_SPAWN = POS_W'(SCREEN_W - 1);
  localparam logic signed [POS_W-1:0] X_MAX     = POS_W'(SCREEN_W - 1);
  localparam logic signed [POS_W-1:0] STEP_S    = POS_W'(STEP);
  localparam logic signed [POS_W-1:0] OFF_LEFT  = POS_W'(-OBS_W);
  localparam logic [6:0]              GAP_MAX   = 7'(SCREEN_H - GAP_H);
  localparam logic [7:0]              GAP_SPAN  = 8'(GAP_H - 1);

  state_t                   state;
  logic signed [POS_W-1:0]  pos;
  logic signed [POS_W-1:0]  pos_next;
  logic signed [POS_W-1:0]  x;
  logic [6:0]               gap;
  logic [COL_W-1:0]         col;
  logic [6:0]               row;
  logic                     last;
  logic                     scanning;
  logic                     visible;
  logic                     in_gap;
  logic                     respawn;

  assign scanning = (state == S_ERASE) || (state == S_DRAW);

  rect_scanner #(
    .COLS  (OBS_W),
    .ROWS  (SCREEN_H),
    .COL_W (COL_W),
    .ROW_W (7)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state == S_IDLE) || (state == S_MOVE)),
    .advance (scanning),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  assign x        = pos + POS_W'(col);
  assign visible  = !x[POS_W-1] && (x <= X_MAX);
  assign in_gap   = (row >= gap) && ({1'b0, row} <= ({1'b0, gap} + GAP_SPAN));
  assign pos_next = pos - STEP_S;
  assign respawn  = (pos_next <= OFF_LEFT);
  assign obs_x    = pos;

`ifdef OBSTACLE_PASSED_EN
  localparam logic signed [POS_W-1:0] RIGHT_OFS = POS_W'(OBS_W - 1);
  localparam logic signed [POS_W-1:0] BIRD_S    = POS_W'(BIRD_X);
  logic signed [POS_W-1:0] old_right;
  logic signed [POS_W-1:0] new_right;
  logic                    passes;
  assign old_right = pos + RIGHT_OFS;
  assign new_right = pos_next + RIGHT_OFS;
  assign passes    = !respawn && (old_right >= BIRD_S) && (new_right < BIRD_S);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      plot    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      x_coord <= '0;
      y_coord <= '0;
      colour  <= BG_COLOUR;
      pos     <= POS_RESET;
      gap     <= clamp_row(gap_y, GAP_MAX);
`ifdef OBSTACLE_PASSED_EN
      passed  <= 1'b0;
`endif
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
`ifdef OBSTACLE_PASSED_EN
      passed <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ERASE;
            busy  <= 1'b1;
          end
        end
        // Off-screen columns still cost a cycle so latency never depends on pos.
        S_ERASE, S_DRAW: begin
          plot    <= visible;
          x_coord <= x[7:0];
          y_coord <= row;
          colour  <= ((state == S_DRAW) && !in_gap) ? OBS_COLOUR : BG_COLOUR;
          if (last) begin
            state <= (state == S_ERASE) ? S_MOVE : S_FIN;
          end
        end
        S_MOVE: begin
          if (respawn) begin
            pos <= POS_SPAWN;
            gap <= clamp_row(gap_y, GAP_MAX);
          end else begin
            pos <= pos_next;
          end
`ifdef OBSTACLE_PASSED_EN
          passed <= passes;
`endif
          state <= S_DRAW;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_drawer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_obstacle_drawer : randomized frames against a pixel-list model       |
// | (optionally checks passed when OBSTACLE_PASSED_EN is defined). rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_obstacle_drawer;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int OW = 8;
  localparam int GH = 30;
  localparam int ST = 7;
  localparam int BX = 20;
  localparam int LAT = 2 * OW * SH + 3;

  logic       clock;
  logic       reset;
  logic       start;
  logic [6:0] gap_y;
  logic [7:0] x_coord;
  logic [6:0] y_coord;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [8:0] obs_x;
  logic       passed;

  int vectors = 0;
  int miscompares = 0;

  int mpos;
  int mgap;
  int exp_passed;
  int exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef OBSTACLE_PASSED_EN
  obstacle_drawer #(.STEP(ST), .BIRD_X(BX)) dut (
    .clock(clock), .reset(reset), .start(start), .gap_y(gap_y),
    .x_coord(x_coord), .y_coord(y_coord), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .passed(passed), .obs_x(obs_x)
  );
`else
  assign passed = 1'b0;
  obstacle_drawer #(.STEP(ST)) dut (
    .clock(clock), .reset(reset), .start(start), .gap_y(gap_y),
    .x_coord(x_coord), .y_coord(y_coord), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .obs_x(obs_x)
  );
`endif

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_gap(input int v);
    return (v > SH - GH) ? (SH - GH) : v;
  endfunction

  function automatic int enc(input int x, input int y, input int c);
    return x * 1024 + y * 8 + c;
  endfunction

  // Expected visible pixels for one erase/move/draw cycle, updating model pos/gap.
  task automatic model_frame(input int gy);
    int np;
    bit resp;
    exp_q.delete();
    for (int c = 0; c < OW; c++)
      for (int r = 0; r < SH; r++)
        if (mpos + c >= 0 && mpos + c < SW) exp_q.push_back(enc(mpos + c, r, 0));
    np   = mpos - ST;
    resp = (np <= -OW);
    exp_passed = (!resp && (mpos + OW - 1 >= BX) && (np + OW - 1 < BX)) ? 1 : 0;
    if (resp) begin
      np   = SW - 1;
      mgap = clamp_gap(gy);
    end
    mpos = np;
    for (int c = 0; c < OW; c++)
      for (int r = 0; r < SH; r++)
        if (mpos + c >= 0 && mpos + c < SW)
          exp_q.push_back(enc(mpos + c, r, (r >= mgap && r < mgap + GH) ? 0 : 2));
  endtask

  task automatic run_frame(input string name, input bit spam);
    int  cyc;
    int  npass;
    int  bad;
    bit  got_done;
    bit  busy_ok;
    int  obs_q[$];
    model_frame(int'(gap_y));
    @(negedge clock);
    start    = 1'b1;
    cyc      = 0;
    npass    = 0;
    got_done = 1'b0;
    busy_ok  = 1'b1;
    while (!got_done && cyc < LAT + 600) begin
      @(negedge clock);
      cyc++;
      if (!spam) start = 1'b0;
      if (plot) obs_q.push_back(enc(int'(x_coord), int'(y_coord), int'(colour)));
      if (passed) npass++;
      if (done) got_done = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({name, "_latency"}, cyc, LAT);
    check({name, "_busy_at_done"}, int'(busy), 0);
    check({name, "_busy_held"}, int'(busy_ok), 1);
    check({name, "_plot_count"}, obs_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs_q[i] != exp_q[i]) bad = i;
    check({name, "_first_bad_pixel"}, bad, -1);
`ifdef OBSTACLE_PASSED_EN
    check({name, "_passed_pulses"}, npass, exp_passed);
`endif
    @(negedge clock);
    check({name, "_done_width"}, int'(done), 0);
    check({name, "_no_restart"}, int'(busy), 0);
    check({name, "_obs_x"}, int'($signed(obs_x)), mpos);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    gap_y = 7'd40;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mpos  = SW;
    mgap  = clamp_gap(40);
    @(negedge clock);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x_coord), 0);
    check("rst_y", int'(y_coord), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_obs_x", int'($signed(obs_x)), SW);

    // 160 - 7k reaches -1 at frame 22 and respawns at frame 23.
    for (int f = 0; f < 28; f++) begin
      if (f == 0) gap_y = 7'd40;
      else if (f == 23) gap_y = 7'd100;
      else gap_y = 7'($urandom_range(0, 127));
      run_frame($sformatf("frame%0d", f), (f == 3) || (f == 25));
    end

    // Abort in the middle of DRAW.
    gap_y = 7'd55;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (OW * SH + 1 + 499) @(negedge clock);
    reset = 1'b1;
    gap_y = 7'd77;
    @(negedge clock);
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_obs_x", int'($signed(obs_x)), SW);
    reset = 1'b0;
    mpos  = SW;
    mgap  = clamp_gap(77);
    @(negedge clock);
    check("abort_idle_plot", int'(plot), 0);
    check("abort_idle_busy", int'(busy), 0);
    run_frame("post_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
